xrm_trigger_config_scheduler: RTL and testbench

- Owns the live configuration for the XRM trigger generator: enable, prescale, and the four bunch-marker positions.
- Host-side writes land in staging registers. A host commit request then copies all staged values to the active outputs in one cycle, aligned to a frame9 boundary.
- This prevents the trigger generator from seeing a half-updated or mid-orbit configuration.
- Sits between the register/config interface and the trigger generator, in the clock127 domain.

---
 rtl/xrm_trigger_config_pkg.sv | 28 ++
 rtl/xrm_config_shadow_bank.sv | 101 ++++++++++
 rtl/xrm_trigger_config_scheduler.sv | 139 +++++++++++++
 tb/tb_xrm_trigger_config_scheduler.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/xrm_trigger_config_pkg.sv
// Shared definitions for the XRM trigger configuration scheduler.
//   state_e         : scheduler FSM states (IDLE, ARMED, APPLY)
//   ADDR_*          : staging register addresses on the host write port
//   *_WIDTH         : field widths of the active configuration
//   FRAME9_TIMEOUT_DEFAULT : cycles to wait for a frame9 edge (2 x 9 x 1280)
package xrm_trigger_config_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    APPLY = 2'd2
  } state_e;

  localparam int unsigned NUM_MARKERS    = 4;
  localparam int unsigned MARKER_WIDTH   = 25;
  localparam int unsigned PRESCALE_WIDTH = 5;
  localparam int unsigned ADDR_WIDTH     = 3;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ENABLE   = 3'd0;
  localparam logic [ADDR_WIDTH-1:0] ADDR_PRESCALE = 3'd1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_MARKER_A = 3'd2;
  localparam logic [ADDR_WIDTH-1:0] ADDR_MARKER_B = 3'd3;
  localparam logic [ADDR_WIDTH-1:0] ADDR_MARKER_C = 3'd4;
  localparam logic [ADDR_WIDTH-1:0] ADDR_MARKER_D = 3'd5;

  localparam int unsigned FRAME9_TIMEOUT_DEFAULT = 23040;

endpackage

// File: rtl/xrm_config_shadow_bank.sv
// Staging + active register pairs for the trigger configuration.
//   wr_en/wr_addr/wr_data : accepted host write, lands in staging next edge
//   load_all              : copies every staging value to the active set
//   enable/prescale/marker_*: active configuration (registered)
// Addresses 6 and 7 decode to nothing, so those writes are dropped.
module xrm_config_shadow_bank
  import xrm_trigger_config_pkg::*;
(
  input  logic                      clock127,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [ADDR_WIDTH-1:0]     wr_addr,
  input  logic [MARKER_WIDTH-1:0]   wr_data,
  input  logic                      load_all,
  output logic                      enable,
  output logic [PRESCALE_WIDTH-1:0] prescale,
  output logic [MARKER_WIDTH-1:0]   marker_a,
  output logic [MARKER_WIDTH-1:0]   marker_b,
  output logic [MARKER_WIDTH-1:0]   marker_c,
  output logic [MARKER_WIDTH-1:0]   marker_d
);

  logic                      stg_enable_q,   stg_enable_d;
  logic [PRESCALE_WIDTH-1:0] stg_prescale_q, stg_prescale_d;
  logic [MARKER_WIDTH-1:0]   stg_marker_a_q, stg_marker_a_d;
  logic [MARKER_WIDTH-1:0]   stg_marker_b_q, stg_marker_b_d;
  logic [MARKER_WIDTH-1:0]   stg_marker_c_q, stg_marker_c_d;
  logic [MARKER_WIDTH-1:0]   stg_marker_d_q, stg_marker_d_d;

  logic                      act_enable_q,   act_enable_d;
  logic [PRESCALE_WIDTH-1:0] act_prescale_q, act_prescale_d;
  logic [MARKER_WIDTH-1:0]   act_marker_a_q, act_marker_a_d;
  logic [MARKER_WIDTH-1:0]   act_marker_b_q, act_marker_b_d;
  logic [MARKER_WIDTH-1:0]   act_marker_c_q, act_marker_c_d;
  logic [MARKER_WIDTH-1:0]   act_marker_d_q, act_marker_d_d;

  always_comb begin
    stg_enable_d   = stg_enable_q;
    stg_prescale_d = stg_prescale_q;
    stg_marker_a_d = stg_marker_a_q;
    stg_marker_b_d = stg_marker_b_q;
    stg_marker_c_d = stg_marker_c_q;
    stg_marker_d_d = stg_marker_d_q;
    if (wr_en) begin
      case (wr_addr)
        ADDR_ENABLE:   stg_enable_d   = wr_data[0];
        ADDR_PRESCALE: stg_prescale_d = wr_data[PRESCALE_WIDTH-1:0];
        ADDR_MARKER_A: stg_marker_a_d = wr_data;
        ADDR_MARKER_B: stg_marker_b_d = wr_data;
        ADDR_MARKER_C: stg_marker_c_d = wr_data;
        ADDR_MARKER_D: stg_marker_d_d = wr_data;
        default: ;
      endcase
    end

    act_enable_d   = load_all ? stg_enable_q   : act_enable_q;
    act_prescale_d = load_all ? stg_prescale_q : act_prescale_q;
    act_marker_a_d = load_all ? stg_marker_a_q : act_marker_a_q;
    act_marker_b_d = load_all ? stg_marker_b_q : act_marker_b_q;
    act_marker_c_d = load_all ? stg_marker_c_q : act_marker_c_q;
    act_marker_d_d = load_all ? stg_marker_d_q : act_marker_d_q;
  end

  always_ff @(posedge clock127) begin
    if (reset) begin
      stg_enable_q   <= 1'b0;
      stg_prescale_q <= '0;
      stg_marker_a_q <= '0;
      stg_marker_b_q <= '0;
      stg_marker_c_q <= '0;
      stg_marker_d_q <= '0;
      act_enable_q   <= 1'b0;
      act_prescale_q <= '0;
      act_marker_a_q <= '0;
      act_marker_b_q <= '0;
      act_marker_c_q <= '0;
      act_marker_d_q <= '0;
    end else begin
      stg_enable_q   <= stg_enable_d;
      stg_prescale_q <= stg_prescale_d;
      stg_marker_a_q <= stg_marker_a_d;
      stg_marker_b_q <= stg_marker_b_d;
      stg_marker_c_q <= stg_marker_c_d;
      stg_marker_d_q <= stg_marker_d_d;
      act_enable_q   <= act_enable_d;
      act_prescale_q <= act_prescale_d;
      act_marker_a_q <= act_marker_a_d;
      act_marker_b_q <= act_marker_b_d;
      act_marker_c_q <= act_marker_c_d;
      act_marker_d_q <= act_marker_d_d;
    end
  end

  assign enable   = act_enable_q;
  assign prescale = act_prescale_q;
  assign marker_a = act_marker_a_q;
  assign marker_b = act_marker_b_q;
  assign marker_c = act_marker_c_q;
  assign marker_d = act_marker_d_q;

endmodule

// File: rtl/xrm_trigger_config_scheduler.sv
// Live configuration owner for the XRM trigger generator.
// Host writes go to staging registers; a commit_req copies the whole staged
// set to the active outputs in one cycle, aligned to a frame9 rising edge
// (or forced after FRAME9_TIMEOUT cycles) so the trigger never sees a torn
// or mid-orbit configuration. If the trigger is currently disabled the
// commit is applied immediately.
//   clock127, reset (sync, active-high)
//   frame9                     : frame9 level, rising edge = orbit boundary
//   wr_valid/wr_ready/wr_addr/wr_data : host write port
//   commit_req / commit_ack    : commit request pulse / applied pulse
//   xrm_trigger_enabled, trig_prescale_N_log2, bunch_marker_*_position
//   update_pending, timeout_error (sticky), commit_count (wrapping)
//   state_dbg                  : current FSM state
//
// Handshake: a write transfers on every clock127 edge where wr_valid and
// wr_ready are both high; wr_ready depends only on the state register and
// is high only in IDLE, so the host must hold wr_valid until it sees ready.
module xrm_trigger_config_scheduler
  import xrm_trigger_config_pkg::*;
#(
  parameter int unsigned FRAME9_TIMEOUT = FRAME9_TIMEOUT_DEFAULT
) (
  input  logic                      clock127,
  input  logic                      reset,
  input  logic                      frame9,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [ADDR_WIDTH-1:0]     wr_addr,
  input  logic [MARKER_WIDTH-1:0]   wr_data,
  input  logic                      commit_req,
  output logic                      commit_ack,
  output logic                      xrm_trigger_enabled,
  output logic [PRESCALE_WIDTH-1:0] trig_prescale_N_log2,
  output logic [MARKER_WIDTH-1:0]   bunch_marker_a_position,
  output logic [MARKER_WIDTH-1:0]   bunch_marker_b_position,
  output logic [MARKER_WIDTH-1:0]   bunch_marker_c_position,
  output logic [MARKER_WIDTH-1:0]   bunch_marker_d_position,
  output logic                      update_pending,
  output logic                      timeout_error,
  output logic [15:0]               commit_count,
  output logic [1:0]                state_dbg
);

  localparam int unsigned TIMER_W = $clog2(FRAME9_TIMEOUT + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(FRAME9_TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               frame9_q;
  logic               timeout_error_q, timeout_error_d;
  logic               commit_ack_q, commit_ack_d;
  logic [15:0]        commit_count_q, commit_count_d;
  logic               load_all;
  logic               frame9_rise;
  logic               wr_en;

  assign frame9_rise = frame9 && !frame9_q;
  assign wr_ready    = (state_q == IDLE);
  assign wr_en       = wr_valid && wr_ready;

  always_comb begin
    state_d         = state_q;
    timer_d         = timer_q;
    timeout_error_d = timeout_error_q;
    commit_ack_d    = 1'b0;
    commit_count_d  = commit_count_q;
    load_all        = 1'b0;
    case (state_q)
      IDLE: begin
        if (commit_req) begin
          // A disabled trigger cannot be disturbed mid-orbit: apply now.
          if (!xrm_trigger_enabled) begin
            state_d = APPLY;
          end else begin
            state_d = ARMED;
            timer_d = '0;
          end
        end
      end
      ARMED: begin
        timer_d = timer_q + 1'b1;
        // The orbit edge wins over a coincident timeout, no error then.
        if (frame9_rise) begin
          state_d = APPLY;
        end else if (timer_q == TIMER_LAST) begin
          timeout_error_d = 1'b1;
          state_d         = APPLY;
        end
      end
      APPLY: begin
        load_all       = 1'b1;
        commit_ack_d   = 1'b1;
        commit_count_d = commit_count_q + 16'd1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock127) begin
    if (reset) begin
      state_q         <= IDLE;
      timer_q         <= '0;
      frame9_q        <= 1'b0;
      timeout_error_q <= 1'b0;
      commit_ack_q    <= 1'b0;
      commit_count_q  <= '0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      frame9_q        <= frame9;
      timeout_error_q <= timeout_error_d;
      commit_ack_q    <= commit_ack_d;
      commit_count_q  <= commit_count_d;
    end
  end

  xrm_config_shadow_bank u_bank (
    .clock127 (clock127),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .load_all (load_all),
    .enable   (xrm_trigger_enabled),
    .prescale (trig_prescale_N_log2),
    .marker_a (bunch_marker_a_position),
    .marker_b (bunch_marker_b_position),
    .marker_c (bunch_marker_c_position),
    .marker_d (bunch_marker_d_position)
  );

  assign update_pending = (state_q == ARMED);
  assign timeout_error  = timeout_error_q;
  assign commit_ack     = commit_ack_q;
  assign commit_count   = commit_count_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_xrm_trigger_config_scheduler.sv
// Bench for xrm_trigger_config_scheduler: directed scenarios followed by
// random traffic, all checked every cycle against a cycle-indexed model
// that tracks staged/active values and schedules commits by deadline.
module tb_xrm_trigger_config_scheduler;

  localparam int T = 23040;

  // clock / reset
  logic        clock127 = 1'b0;
  logic        reset    = 1'b1;
  always #5 clock127 = ~clock127;

  logic        frame9 = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [2:0]  wr_addr = '0;
  logic [24:0] wr_data = '0;
  logic        commit_req = 1'b0;
  logic        commit_ack;
  logic        xrm_trigger_enabled;
  logic [4:0]  trig_prescale_N_log2;
  logic [24:0] bunch_marker_a_position;
  logic [24:0] bunch_marker_b_position;
  logic [24:0] bunch_marker_c_position;
  logic [24:0] bunch_marker_d_position;
  logic        update_pending;
  logic        timeout_error;
  logic [15:0] commit_count;
  logic [1:0]  state_dbg;

  xrm_trigger_config_scheduler dut (
    .clock127                (clock127),
    .reset                   (reset),
    .frame9                  (frame9),
    .wr_valid                (wr_valid),
    .wr_ready                (wr_ready),
    .wr_addr                 (wr_addr),
    .wr_data                 (wr_data),
    .commit_req              (commit_req),
    .commit_ack              (commit_ack),
    .xrm_trigger_enabled     (xrm_trigger_enabled),
    .trig_prescale_N_log2    (trig_prescale_N_log2),
    .bunch_marker_a_position (bunch_marker_a_position),
    .bunch_marker_b_position (bunch_marker_b_position),
    .bunch_marker_c_position (bunch_marker_c_position),
    .bunch_marker_d_position (bunch_marker_d_position),
    .update_pending          (update_pending),
    .timeout_error           (timeout_error),
    .commit_count            (commit_count),
    .state_dbg               (state_dbg)
  );

  // scoreboard
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // reference model: index 0 enable, 1 prescale, 2..5 markers a..d
  logic [24:0] m_stg[6];
  logic [24:0] m_act[6];
  logic [15:0] m_cnt;
  bit          m_terr, m_ack, m_pending, m_prev_f9;
  int          m_cyc, m_deadline, m_apply_at;

  task automatic model_clear();
    for (int i = 0; i < 6; i++) begin
      m_stg[i] = '0;
      m_act[i] = '0;
    end
    m_cnt = '0; m_terr = 0; m_ack = 0; m_pending = 0; m_prev_f9 = 0;
    m_cyc = 0; m_deadline = 0; m_apply_at = -1;
    exp_q.delete();
  endtask

  // Predict the effect of the coming clock edge from the driven inputs.
  task automatic model_edge();
    bit rise;
    rise  = frame9 && !m_prev_f9;
    m_ack = 0;
    if (m_apply_at == m_cyc) begin
      for (int i = 0; i < 6; i++) m_act[i] = m_stg[i];
      m_cnt      = m_cnt + 16'd1;
      m_ack      = 1;
      m_apply_at = -1;
      exp_q.push_back(m_cnt);
    end else if (m_pending) begin
      if (rise) begin
        m_pending  = 0;
        m_apply_at = m_cyc + 1;
      end else if (m_cyc == m_deadline) begin
        m_terr     = 1;
        m_pending  = 0;
        m_apply_at = m_cyc + 1;
      end
    end else begin
      if (wr_valid) begin
        case (wr_addr)
          3'd0:    m_stg[0] = {24'd0, wr_data[0]};
          3'd1:    m_stg[1] = {20'd0, wr_data[4:0]};
          3'd2, 3'd3, 3'd4, 3'd5: m_stg[wr_addr - 3'd2 + 3'd2] = wr_data;
          default: ;
        endcase
      end
      if (commit_req) begin
        if (m_act[0][0] == 1'b0) m_apply_at = m_cyc + 1;
        else begin
          m_pending  = 1;
          m_deadline = m_cyc + T;
        end
      end
    end
    m_prev_f9 = frame9;
    m_cyc++;
  endtask

  task automatic check_all();
    logic [1:0] exp_state;
    exp_state = m_pending ? 2'd1 : ((m_apply_at >= 0) ? 2'd2 : 2'd0);
    check_eq("enable",   32'(xrm_trigger_enabled), 32'(m_act[0]));
    check_eq("prescale", 32'(trig_prescale_N_log2), 32'(m_act[1]));
    check_eq("marker_a", 32'(bunch_marker_a_position), 32'(m_act[2]));
    check_eq("marker_b", 32'(bunch_marker_b_position), 32'(m_act[3]));
    check_eq("marker_c", 32'(bunch_marker_c_position), 32'(m_act[4]));
    check_eq("marker_d", 32'(bunch_marker_d_position), 32'(m_act[5]));
    check_eq("commit_ack", 32'(commit_ack), 32'(m_ack));
    check_eq("commit_count", 32'(commit_count), 32'(m_cnt));
    check_eq("timeout_error", 32'(timeout_error), 32'(m_terr));
    check_eq("update_pending", 32'(update_pending), 32'(m_pending));
    check_eq("wr_ready", 32'(wr_ready), 32'(exp_state == 2'd0));
    check_eq("state", 32'(state_dbg), 32'(exp_state));
    if (commit_ack === 1'b1) begin
      check_eq("ack_queued", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check_eq("ack_count", 32'(commit_count), 32'(exp_q.pop_front()));
    end
  endtask

  // driver tasks
  task automatic step(input bit v, input logic [2:0] a, input logic [24:0] d,
                      input bit c, input bit f);
    wr_valid = v; wr_addr = a; wr_data = d; commit_req = c; frame9 = f;
    model_edge();
    @(posedge clock127); #1;
    check_all();
  endtask

  task automatic idle(input int n, input bit f);
    for (int i = 0; i < n; i++) step(0, 3'd0, 25'd0, 0, f);
  endtask

  task automatic do_reset(input int n);
    reset = 1; wr_valid = 0; commit_req = 0; frame9 = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clock127); #1;
      model_clear();
      check_all();
    end
    reset = 0;
  endtask

  logic [15:0] c0;
  bit          flv;
  int          r;

  initial begin
    model_clear();
    do_reset(3);
    check_eq("rst_count", 32'(commit_count), 32'd0);
    check_eq("rst_ready", 32'(wr_ready), 32'd1);

    // staged write without commit stays invisible
    step(1, 3'd2, 25'h1FF0008, 0, 0);
    idle(3, 0);
    check_eq("no_commit_marker_a", 32'(bunch_marker_a_position), 32'd0);

    // disabled path: applied two cycles after commit_req
    step(1, 3'd1, 25'd2, 0, 0);
    step(1, 3'd2, 25'h1FF0000, 0, 0);
    step(0, 3'd0, 25'd0, 1, 0);
    idle(2, 0);
    check_eq("dis_prescale", 32'(trig_prescale_N_log2), 32'd2);
    check_eq("dis_marker_a", 32'(bunch_marker_a_position), 32'h1FF0000);
    check_eq("dis_count", 32'(commit_count), 32'd1);

    // enable, then an aligned commit
    step(1, 3'd0, 25'd1, 1, 0);
    idle(2, 0);
    step(1, 3'd3, 25'h0010008, 0, 0);
    step(0, 3'd0, 25'd0, 1, 0);
    idle(3, 0);
    check_eq("arm_pending", 32'(update_pending), 32'd1);
    check_eq("arm_ready", 32'(wr_ready), 32'd0);
    check_eq("arm_marker_b_old", 32'(bunch_marker_b_position), 32'd0);
    step(0, 3'd0, 25'd0, 0, 1);
    step(0, 3'd0, 25'd0, 0, 1);
    check_eq("rise_marker_b", 32'(bunch_marker_b_position), 32'h0010008);
    check_eq("rise_pending", 32'(update_pending), 32'd0);
    check_eq("rise_terr", 32'(timeout_error), 32'd0);

    // timeout with frame9 held low
    step(0, 3'd0, 25'd0, 1, 0);
    idle(T + 3, 0);
    check_eq("to_terr", 32'(timeout_error), 32'd1);
    step(0, 3'd0, 25'd0, 1, 0);
    idle(2, 0);
    step(0, 3'd0, 25'd0, 0, 1);
    idle(3, 1);
    check_eq("to_terr_sticky", 32'(timeout_error), 32'd1);

    // disable via aligned commit, then same-cycle write + commit
    step(1, 3'd0, 25'd0, 1, 0);
    step(0, 3'd0, 25'd0, 0, 1);
    idle(3, 0);
    step(1, 3'd3, 25'd5, 1, 0);
    idle(2, 0);
    check_eq("same_cycle_marker_b", 32'(bunch_marker_b_position), 32'd5);

    // second commit_req while ARMED is ignored
    step(1, 3'd0, 25'd1, 1, 0);
    idle(2, 0);
    c0 = m_cnt;
    step(0, 3'd0, 25'd0, 1, 0);
    step(0, 3'd0, 25'd0, 1, 0);
    step(0, 3'd0, 25'd0, 1, 1);
    idle(4, 0);
    check_eq("ignored_req_count", 32'(commit_count), 32'(c0 + 16'd1));

    // reset while ARMED
    step(0, 3'd0, 25'd0, 1, 0);
    idle(2, 0);
    do_reset(2);
    idle(1, 0);
    check_eq("rst_arm_enable", 32'(xrm_trigger_enabled), 32'd0);
    check_eq("rst_arm_count", 32'(commit_count), 32'd0);
    check_eq("rst_arm_ready", 32'(wr_ready), 32'd1);
    check_eq("rst_arm_ack", 32'(commit_ack), 32'd0);

    // random traffic
    flv = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset(1);
      if ($urandom_range(0, 15) == 0) flv = !flv;
      r = $urandom_range(0, 7);
      step($urandom_range(0, 1) == 1, 3'(r), 25'($urandom),
           $urandom_range(0, 7) == 0, flv);
    end

    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
